// File: rtl/load_unit_pkg.sv
// Shared definitions for the load alignment unit: access size encodings,
// controller state enum and a byte-count helper.
package load_unit_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    DONE
  } loadState_t;

  // Number of bytes moved by an access of the given size encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte extraction for loads: shifts the two-beat window
// {beat1, beat0} right by the byte offset, keeps the low field of the
// requested size and sign- or zero-extends it to DATA_W.
module load_extract
  import load_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0]          beats,
  input  logic [$clog2(DATA_W/8)-1:0]  off,
  input  logic [1:0]                   size,
  input  logic                         isUnsigned,
  output logic [DATA_W-1:0]            extData
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              signBit;

  // Align the addressed field to bit 0, then mask and extend it.
  always_comb begin
    shifted = DATA_W'(beats >> {off, 3'b000});
    mask    = '1;
    signBit = 1'b0;
    case (size)
      SZ_BYTE: begin
        mask    = DATA_W'(8'hFF);
        signBit = shifted[7];
      end
      SZ_HALF: begin
        mask    = DATA_W'(16'hFFFF);
        signBit = shifted[15];
      end
      SZ_WORD: begin
        mask    = DATA_W'(32'hFFFF_FFFF);
        signBit = shifted[31];
      end
      default: begin
        // Full-width access: nothing to extend, unsigned flag irrelevant.
        mask    = '1;
        signBit = 1'b0;
      end
    endcase
    extData = (shifted & mask) | ((signBit & ~isUnsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load unit: accepts one load at a time, issues word-aligned
// read(s) to data memory and returns the extended result to writeback.
// Optional macro LOAD_SPLIT_ACCESS_EN: when defined, misaligned loads are
// serviced (two beats if they cross a word boundary); when undefined they
// complete immediately with wb_err and no memory traffic.
//
// state | meaning
// IDLE  | ready for a new request
// REQ0  | first read request presented to memory
// WAIT0 | waiting for first read data
// REQ1  | second read request (word-crossing access)
// WAIT1 | waiting for second read data
// DONE  | one-cycle writeback pulse
module load_align_unit
  import load_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  loadState_t        state, stateNext;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              unsQ;
  logic              errQ;
  logic              crossQ;
  logic [DATA_W-1:0] beat0, beat1;
  logic [DATA_W-1:0] extData;
  logic [ADDR_W-1:0] alignedAddr;
  logic              handshake;
  logic              reqMis, reqCross, reqIllegal, reqErr;
  int                reqOff, reqBytes;

  assign handshake   = req_valid && (state == IDLE);
  assign alignedAddr = {addrQ[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Classify the incoming request: misalignment, word crossing, legality.
  always_comb begin
    reqOff     = int'(req_addr[OFF_W-1:0]);
    reqBytes   = int'(size_bytes(req_size));
    reqMis     = (reqOff & (reqBytes - 1)) != 0;
    reqCross   = (reqOff + reqBytes) > BYTES;
    reqIllegal = (req_size == SZ_DWORD) && (DATA_W == 32);
`ifdef LOAD_SPLIT_ACCESS_EN
    reqErr     = reqIllegal;
`else
    reqErr     = reqIllegal || reqMis;
`endif
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Request capture and read-data beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ  <= '0;
      sizeQ  <= SZ_BYTE;
      unsQ   <= 1'b0;
      errQ   <= 1'b0;
      crossQ <= 1'b0;
      beat0  <= '0;
      beat1  <= '0;
    end else begin
      if (handshake) begin
        addrQ  <= req_addr;
        sizeQ  <= req_size;
        unsQ   <= req_unsigned;
        errQ   <= reqErr;
        crossQ <= reqCross;
        beat1  <= '0;
      end
      if (state == WAIT0 && mem_rsp_valid) beat0 <= mem_rsp_data;
      if (state == WAIT1 && mem_rsp_valid) beat1 <= mem_rsp_data;
    end
  end

  load_extract #(.DATA_W(DATA_W)) uExtract (
    .beats      ({beat1, beat0}),
    .off        (addrQ[OFF_W-1:0]),
    .size       (sizeQ),
    .isUnsigned (unsQ),
    .extData    (extData)
  );

  // Next-state and Moore outputs.
  always_comb begin
    stateNext    = state;
    req_ready    = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_addr  = '0;
    wb_valid     = 1'b0;
    wb_data      = '0;
    wb_err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) stateNext = reqErr ? DONE : REQ0;
      end
      REQ0: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = alignedAddr;
        if (mem_rd_ready) stateNext = WAIT0;
      end
      WAIT0: begin
        if (mem_rsp_valid) stateNext = crossQ ? REQ1 : DONE;
      end
      REQ1: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = alignedAddr + ADDR_W'(BYTES);
        if (mem_rd_ready) stateNext = WAIT1;
      end
      WAIT1: begin
        if (mem_rsp_valid) stateNext = DONE;
      end
      DONE: begin
        wb_valid  = 1'b1;
        wb_err    = errQ;
        wb_data   = errQ ? '0 : extData;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (DATA_W=32). Memory holds
// 0x100 = 0x8899AABB and 0x104 = 0x11223344.
module tb_load_align_unit;
  import load_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_ready  (mem_rd_ready),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_err        (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h100: return 32'h8899AABB;
      32'h104: return 32'h11223344;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // One load: drives the request, acts as memory (optional ready stall,
  // response delay, spurious response while stalled) and checks the result.
  // expLat counts the accept cycle as cycle 1.
  task automatic doLoad(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input int readyStall, input int rspDelay,
                        input bit spurious, input logic [31:0] expData, input logic expErr,
                        input int expReads, input int expLat);
    int          cyc, reads, validSeen, stallLeft, rspWait;
    bit          pending, done, busyReady;
    logic [31:0] rdAddr, expAddr0, gotData;
    logic        gotErr;
    int          gotLat;
    expAddr0  = {addr[31:2], 2'b00};
    reads     = 0;
    validSeen = 0;
    stallLeft = readyStall;
    rspWait   = 0;
    pending   = 0;
    done      = 0;
    busyReady = 0;
    rdAddr    = '0;
    gotData   = '0;
    gotErr    = 1'b0;
    gotLat    = 0;
    @(negedge clk);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid     = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rd_ready  = 1'b0;
      if (wb_valid) begin
        done    = 1;
        gotData = wb_data;
        gotErr  = wb_err;
        gotLat  = cyc;
      end else begin
        if (req_ready) busyReady = 1;
        if (pending) begin
          if (rspWait > 0) rspWait--;
          else begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memWord(rdAddr);
            pending       = 0;
          end
        end else if (mem_rd_valid) begin
          validSeen++;
          chk({tag, "/rd_addr"}, mem_rd_addr, expAddr0 + 32'(4 * reads));
          if (stallLeft > 0) begin
            stallLeft--;
            if (spurious) begin
              mem_rsp_valid = 1'b1;
              mem_rsp_data  = 32'hFFFF_FFFF;
            end
          end else begin
            mem_rd_ready = 1'b1;
            rdAddr       = mem_rd_addr;
            reads++;
            pending      = 1;
            rspWait      = rspDelay;
          end
        end
      end
    end
    if (!done) begin
      chk({tag, "/timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "/wb_data"}, gotData, expData);
      chk({tag, "/wb_err"}, 32'(gotErr), 32'(expErr));
      chk({tag, "/reads"}, 32'(reads), 32'(expReads));
      chk({tag, "/latency"}, 32'(gotLat), 32'(expLat));
      chk({tag, "/busy_ready"}, 32'(busyReady), 32'd0);
      if (expErr) chk({tag, "/rd_valid_seen"}, 32'(validSeen), 32'd0);
      @(negedge clk);
      chk({tag, "/wb_pulse"}, 32'(wb_valid), 32'd0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_size      = SZ_BYTE;
    req_unsigned  = 1'b0;
    mem_rd_ready  = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    repeat (2) @(negedge clk);
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/mem_rd_valid", 32'(mem_rd_valid), 32'd0);
    chk("rst/mem_rd_addr", mem_rd_addr, 32'd0);
    chk("rst/wb_valid", 32'(wb_valid), 32'd0);
    chk("rst/wb_data", wb_data, 32'd0);
    chk("rst/wb_err", 32'(wb_err), 32'd0);
    reset = 1'b0;

    doLoad("lb100",  32'h100, SZ_BYTE, 1'b0, 0, 0, 0, 32'hFFFF_FFBB, 1'b0, 1, 4);
    doLoad("lbu103", 32'h103, SZ_BYTE, 1'b1, 0, 0, 0, 32'h0000_0088, 1'b0, 1, 4);
    doLoad("lh102",  32'h102, SZ_HALF, 1'b0, 0, 0, 0, 32'hFFFF_8899, 1'b0, 1, 4);
    doLoad("lw100",  32'h100, SZ_WORD, 1'b0, 0, 0, 0, 32'h8899_AABB, 1'b0, 1, 4);
    doLoad("lhu106", 32'h106, SZ_HALF, 1'b1, 0, 0, 0, 32'h0000_1122, 1'b0, 1, 4);
    doLoad("lb107",  32'h107, SZ_BYTE, 1'b0, 0, 0, 0, 32'h0000_0011, 1'b0, 1, 4);
`ifdef LOAD_SPLIT_ACCESS_EN
    doLoad("lw102",  32'h102, SZ_WORD, 1'b0, 0, 0, 0, 32'h3344_8899, 1'b0, 2, 6);
    doLoad("lh103",  32'h103, SZ_HALF, 1'b0, 0, 0, 0, 32'h0000_4488, 1'b0, 2, 6);
`else
    doLoad("lw102",  32'h102, SZ_WORD, 1'b0, 0, 0, 0, 32'h0000_0000, 1'b1, 0, 2);
    doLoad("lh103",  32'h103, SZ_HALF, 1'b0, 0, 0, 0, 32'h0000_0000, 1'b1, 0, 2);
`endif
    doLoad("ld100",  32'h100, SZ_DWORD, 1'b0, 0, 0, 0, 32'h0000_0000, 1'b1, 0, 2);
    doLoad("stall",  32'h102, SZ_BYTE, 1'b0, 3, 2, 1, 32'hFFFF_FF99, 1'b0, 1, 9);

    // Reset while waiting for read data.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h100;
    req_size  = SZ_BYTE;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst/rd_valid_req0", 32'(mem_rd_valid), 32'd1);
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    chk("midrst/rd_valid_wait0", 32'(mem_rd_valid), 32'd0);
    chk("midrst/busy_ready", 32'(req_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("midrst/req_ready", 32'(req_ready), 32'd1);
    chk("midrst/mem_rd_valid", 32'(mem_rd_valid), 32'd0);
    chk("midrst/mem_rd_addr", mem_rd_addr, 32'd0);
    chk("midrst/wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst/wb_data", wb_data, 32'd0);
    chk("midrst/wb_err", 32'(wb_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doLoad("lb101", 32'h101, SZ_BYTE, 1'b0, 0, 0, 0, 32'hFFFF_FFAA, 1'b0, 1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
